// File: rtl/aes_arbiter.sv
// Round-robin arbiter sharing one AES core between two requesters.
// Optional WAIT timeout abort is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_start,
    input  logic [127:0] req0_data,
    input  logic [127:0] req0_key,
    output logic         req0_busy,
    output logic         req0_done,
    output logic [127:0] req0_result,
    input  logic         req1_start,
    input  logic [127:0] req1_data,
    input  logic [127:0] req1_key,
    output logic         req1_busy,
    output logic         req1_done,
    output logic [127:0] req1_result,
    output logic         aes_start,
    output logic [127:0] aes_in,
    output logic [127:0] aes_key,
    input  logic [127:0] aes_out,
    input  logic         aes_done,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t       state;
    state_t       state_nxt;
    logic         grant;
    logic         grant_nxt;
    logic         last_grant;
    logic         pending0;
    logic         pending1;
    logic         accept0;
    logic         accept1;
    logic         complete;
    logic         timeout_hit;
    logic [127:0] op0_data;
    logic [127:0] op0_key;
    logic [127:0] op1_data;
    logic [127:0] op1_key;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("aes_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign req0_busy = pending0 || (state != IDLE && !grant);
    assign req1_busy = pending1 || (state != IDLE && grant);
    assign accept0   = req0_start && !req0_busy;
    assign accept1   = req1_start && !req1_busy;
    assign complete  = (state == WAIT) && (aes_done || timeout_hit);

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // The WAIT state lasts exactly TIMEOUT_CYCLES cycles before aborting.
    assign timeout_hit = (state == WAIT) && !aes_done
                         && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            pending0   <= 1'b0;
            pending1   <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == DELIVER) begin
                last_grant <= grant;
            end
            if (accept0) begin
                pending0 <= 1'b1;
            end else if (complete && !grant) begin
                pending0 <= 1'b0;
            end
            if (accept1) begin
                pending1 <= 1'b1;
            end else if (complete && grant) begin
                pending1 <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        aes_start = 1'b0;
        req0_done = 1'b0;
        req1_done = 1'b0;
        case (state)
            IDLE: begin
                if (pending0 || pending1) begin
                    // On a tie, the requester not served last wins.
                    grant_nxt = (pending0 && pending1) ? !last_grant : pending1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                aes_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (complete) begin
                    state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                req0_done = !grant;
                req1_done = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept0) begin
            op0_data <= req0_data;
            op0_key  <= req0_key;
        end
        if (accept1) begin
            op1_data <= req1_data;
            op1_key  <= req1_key;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            aes_in      <= '0;
            aes_key     <= '0;
            req0_result <= '0;
            req1_result <= '0;
        end else begin
            if (state == IDLE && state_nxt == ISSUE) begin
                aes_in  <= grant_nxt ? op1_data : op0_data;
                aes_key <= grant_nxt ? op1_key  : op0_key;
            end
            // An aborted operation delivers an all-zero result.
            if (complete && !grant) begin
                req0_result <= aes_done ? aes_out : '0;
            end
            if (complete && grant) begin
                req1_result <= aes_done ? aes_out : '0;
            end
        end
    end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles spent in WAIT before abort (used only with AES_ARB_TIMEOUT_EN).
REQ-002 SHALL have the following ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- req0_start  input  1  single-cycle request pulse, requester 0.
- req0_data  input  128  plaintext block, requester 0; sampled with req0_start.
- req0_key  input  128  key, requester 0; sampled with req0_start.
- req0_busy  output  1  requester 0 request pending or in service.
- req0_done  output  1  single-cycle completion pulse, requester 0.
- req0_result  output  128  registered ciphertext, requester 0.
- req1_start, req1_data, req1_key, req1_busy, req1_done, req1_result: same as above, for requester 1.
- aes_start  output  1  single-cycle start to the AES core.
- aes_in  output  128  registered block to the AES core.
- aes_key  output  128  registered key to the AES core.
- aes_out  input  128  AES core ciphertext.
- aes_done  input  1  AES core completion pulse.
- timeout_err  output  1  sticky timeout flag.

Function
REQ-003 SHALL share one AES core between two requesters with round-robin arbitration.
REQ-004 SHALL respond to reqN_start=1 while reqN_busy=0 as follows: at the next edge, capture reqN_data/reqN_key into per-requester operand registers and set pendingN.
REQ-005 SHALL ignore reqN_start while reqN_busy=1: no capture, operands unchanged.
REQ-006 SHALL drive reqN_busy = pendingN OR (state!=IDLE AND grant==N).
REQ-007 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
REQ-008 IDLE: SHALL stay while no pendingN; otherwise select grant, load aes_in/aes_key from the granted operands, and go to ISSUE.
REQ-009 Arbitration: SHALL grant the single pending requester; when both are pending, SHALL grant the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-010 ISSUE: SHALL assert aes_start for exactly one cycle, then go to WAIT.
REQ-011 WAIT: on aes_done=1, SHALL capture aes_out into reqG_result, clear pendingG, and go to DELIVER.
REQ-012 DELIVER: SHALL assert reqG_done for one cycle, update the last-grant pointer to G, then go to IDLE.
REQ-013 SHALL ignore aes_done in any state other than WAIT.
REQ-014 Latency: start pulse at cycle 0 -> aes_start at cycle 2; aes_done at cycle k -> reqG_done at cycle k+1.
REQ-015 SHALL hold aes_in/aes_key stable from ISSUE through WAIT.
REQ-016 SHALL hold reqN_result until the next completion for that requester.
REQ-017 A request from the non-granted requester during service SHALL be captured normally and served after DELIVER (IDLE re-arbitrates).
REQ-018 A start from the granted requester during DELIVER SHALL be ignored (busy still 1).
REQ-019 SHALL never assert both reqN_done outputs in the same cycle, and SHALL never assert aes_start outside ISSUE.

Reset
REQ-020 On rst=0 at a clock edge, SHALL set: state=IDLE, pending0/1=0, last-grant=1, timeout counter=0.
REQ-021 On rst=0 at a clock edge, SHALL clear to 0: aes_start, aes_in, aes_key, req*_done, req*_result, timeout_err.
REQ-022 Reset mid-operation SHALL abandon the current request with no done pulse; the bench must also reset the AES core.

Configuration
REQ-023 Macro AES_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT, cleared on entry.
REQ-024 AES_ARB_TIMEOUT_EN defined: after TIMEOUT_CYCLES cycles in WAIT without aes_done, SHALL set timeout_err (sticky until reset), load reqG_result=0, clear pendingG, and go to DELIVER, which pulses reqG_done.
REQ-025 AES_ARB_TIMEOUT_EN undefined: SHALL wait indefinitely in WAIT, tie timeout_err to 0, and synthesize no counter.

Verification
REQ-026 Req0 start with key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> aes_start at cycle 2; req0_done one cycle after aes_done; req0_result=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-027 Req0 and req1 start in the same cycle after reset -> req0 served first, then req1; aes_start pulses exactly twice; done pulses in order req0, req1.
REQ-028 Req1 start while req0 is in WAIT, then req0 start again after req0_done -> req1 served before the second req0 (round-robin).
REQ-029 Req0 start issued twice while busy, with different data -> second start ignored; result matches the first data.
REQ-030 With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold aes_done=0 -> timeout_err=1 after 8 WAIT cycles; req0_done pulses; req0_result=0.
REQ-031 Assert rst=0 during WAIT -> all outputs 0 next cycle; no done pulse; a new request afterwards completes normally.
